// File: rtl/snoop_cache_ctrl.sv
// Direct-mapped MSI cache controller with a snooping bus port and memory write-back.
// Define SNOOP_STATS_EN to add saturating hit / miss / snoop-invalidation counters.
module snoop_cache_ctrl #(
    parameter int NUM_BLOCKS = 4,
    parameter int TAG_W      = 5,
    parameter int DATA_W     = 8,
    parameter int PROC_ID    = 0,
    localparam int IW = $clog2(NUM_BLOCKS),
    localparam int AW = TAG_W + IW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req_valid,
    input  logic              cpu_op,
    input  logic [IW-1:0]     cpu_index,
    input  logic [TAG_W-1:0]  cpu_tag,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_cmd,
    output logic [AW-1:0]     bus_addr,
    output logic [1:0]        bus_src,
    input  logic [1:0]        snp_cmd,
    input  logic [AW-1:0]     snp_addr,
    input  logic [1:0]        snp_src,
    output logic              snp_hit,
    output logic [DATA_W-1:0] snp_data,
    output logic              snp_data_valid,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_valid,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses,
    output logic [15:0]       stat_snp_inv
`endif
);

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_RD   = 2'd1;
    localparam logic [1:0] CMD_RDX  = 2'd2;
    localparam logic [1:0] CMD_UPGR = 2'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, ARB, WAIT_FILL, DONE} fsm_t;

    fsm_t              state;
    logic [1:0]        line_state [NUM_BLOCKS];
    logic [TAG_W-1:0]  line_tag   [NUM_BLOCKS];
    logic [DATA_W-1:0] line_data  [NUM_BLOCKS];

    logic              req_op;
    logic [IW-1:0]     req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_cmd;

    logic [IW-1:0]     snp_idx;
    logic [TAG_W-1:0]  snp_tag;
    logic              snp_active;
    logic              snp_line_hit;
    logic              snp_dirty;
    logic              snp_supply;
    logic              snp_wb;
    logic              snp_inv;
    logic              snp_same_idx;
    logic              lk_hit;
    logic              upgr_lost;
    logic [1:0]        arb_cmd;

    assign bus_src = 2'(PROC_ID);

    // Snoop decode: only foreign transactions act on our lines.
    assign snp_idx      = snp_addr[IW-1:0];
    assign snp_tag      = snp_addr[AW-1:IW];
    assign snp_active   = (snp_cmd != CMD_NONE) && (snp_src != bus_src);
    assign snp_line_hit = snp_active && (line_state[snp_idx] != ST_I) && (line_tag[snp_idx] == snp_tag);
    assign snp_dirty    = snp_line_hit && (line_state[snp_idx] == ST_M);
    assign snp_supply   = snp_dirty && (snp_cmd != CMD_UPGR);
    assign snp_wb       = snp_dirty && (snp_cmd == CMD_RD);
    assign snp_inv      = snp_line_hit && ((snp_cmd == CMD_RDX) || (snp_cmd == CMD_UPGR));
    assign snp_same_idx = snp_active && (snp_idx == req_index);

    assign lk_hit = (line_state[req_index] != ST_I) && (line_tag[req_index] == req_tag);

    // An upgrade whose S copy has been (or is being) invalidated must fetch the line again.
    assign upgr_lost = (snp_inv && (snp_idx == req_index)) ||
                       (line_state[req_index] != ST_S) || (line_tag[req_index] != req_tag);
    assign arb_cmd   = ((req_cmd == CMD_UPGR) && upgr_lost) ? CMD_RDX : req_cmd;

    // Controller sequencing, line array updates and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            line_state     <= '{default: ST_I};
            line_tag       <= '{default: {TAG_W{1'b0}}};
            line_data      <= '{default: {DATA_W{1'b0}}};
            req_op         <= 1'b0;
            req_index      <= {IW{1'b0}};
            req_tag        <= {TAG_W{1'b0}};
            req_wdata      <= {DATA_W{1'b0}};
            req_cmd        <= CMD_NONE;
            cpu_ready      <= 1'b0;
            cpu_rdata      <= {DATA_W{1'b0}};
            cpu_hit        <= 1'b0;
            bus_req        <= 1'b0;
            bus_cmd        <= CMD_NONE;
            bus_addr       <= {AW{1'b0}};
            snp_hit        <= 1'b0;
            snp_data       <= {DATA_W{1'b0}};
            snp_data_valid <= 1'b0;
            wb_valid       <= 1'b0;
            wb_addr        <= {AW{1'b0}};
            wb_data        <= {DATA_W{1'b0}};
        end else begin
            cpu_ready      <= 1'b0;
            bus_cmd        <= CMD_NONE;
            wb_valid       <= 1'b0;
            snp_hit        <= snp_line_hit;
            snp_data_valid <= snp_supply;
            snp_data       <= snp_supply ? line_data[snp_idx] : {DATA_W{1'b0}};

            if (snp_wb) begin
                line_state[snp_idx] <= ST_S;
                wb_valid            <= 1'b1;
                wb_addr             <= snp_addr;
                wb_data             <= line_data[snp_idx];
            end else if (snp_inv) begin
                line_state[snp_idx] <= ST_I;
            end

            // Controller writes follow the snoop update so they take effect last.
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_op    <= cpu_op;
                        req_index <= cpu_index;
                        req_tag   <= cpu_tag;
                        req_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (snp_same_idx) begin
                        state <= LOOKUP;
                    end else if (lk_hit && !req_op) begin
                        cpu_rdata <= line_data[req_index];
                        cpu_hit   <= 1'b1;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
                    end else if (lk_hit && (line_state[req_index] == ST_M)) begin
                        line_data[req_index] <= req_wdata;
                        cpu_rdata <= req_wdata;
                        cpu_hit   <= 1'b1;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
                    end else if (lk_hit) begin
                        req_cmd <= CMD_UPGR;
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end else if (line_state[req_index] == ST_M) begin
                        req_cmd <= req_op ? CMD_RDX : CMD_RD;
                        state   <= EVICT;
                    end else begin
                        req_cmd <= req_op ? CMD_RDX : CMD_RD;
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end
                end
                EVICT: begin
                    // A snoop may already have written the victim back or taken it away.
                    if (snp_wb || snp_same_idx) begin
                        state <= EVICT;
                    end else begin
                        if (line_state[req_index] == ST_M) begin
                            wb_valid <= 1'b1;
                            wb_addr  <= {line_tag[req_index], req_index};
                            wb_data  <= line_data[req_index];
                        end
                        line_state[req_index] <= ST_I;
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end
                end
                ARB: begin
                    req_cmd <= arb_cmd;
                    if (bus_gnt) begin
                        bus_req  <= 1'b0;
                        bus_cmd  <= arb_cmd;
                        bus_addr <= {req_tag, req_index};
                        if (arb_cmd == CMD_UPGR) begin
                            line_state[req_index] <= ST_M;
                            line_data[req_index]  <= req_wdata;
                            cpu_rdata <= req_wdata;
                            cpu_hit   <= 1'b1;
                            cpu_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= WAIT_FILL;
                        end
                    end else begin
                        bus_req <= 1'b1;
                    end
                end
                WAIT_FILL: begin
                    if (fill_valid) begin
                        line_tag[req_index] <= req_tag;
                        if (req_cmd == CMD_RD) begin
                            line_state[req_index] <= ST_S;
                            line_data[req_index]  <= fill_data;
                            cpu_rdata <= fill_data;
                        end else begin
                            line_state[req_index] <= ST_M;
                            line_data[req_index]  <= req_wdata;
                            cpu_rdata <= req_wdata;
                        end
                        cpu_hit   <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    cpu_hit <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_STATS_EN
    // Saturating event counters sampled on request completion and snoop invalidation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_hits    <= 16'd0;
            stat_misses  <= 16'd0;
            stat_snp_inv <= 16'd0;
        end else begin
            if ((state == DONE) && cpu_hit && (stat_hits != 16'hFFFF)) begin
                stat_hits <= stat_hits + 16'd1;
            end
            if ((state == DONE) && !cpu_hit && (stat_misses != 16'hFFFF)) begin
                stat_misses <= stat_misses + 16'd1;
            end
            if (snp_inv && (stat_snp_inv != 16'hFFFF)) begin
                stat_snp_inv <= stat_snp_inv + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Self-checking bench for snoop_cache_ctrl: directed scenarios plus random traffic
// checked against an MSI line table kept in the bench.
module tb_snoop_cache_ctrl;

    logic       clock;
    logic       reset;
    logic       cpu_req_valid;
    logic       cpu_op;
    logic [1:0] cpu_index;
    logic [4:0] cpu_tag;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic       cpu_hit;
    logic       bus_req;
    logic       bus_gnt;
    logic [1:0] bus_cmd;
    logic [6:0] bus_addr;
    logic [1:0] bus_src;
    logic [1:0] snp_cmd;
    logic [6:0] snp_addr;
    logic [1:0] snp_src;
    logic       snp_hit;
    logic [7:0] snp_data;
    logic       snp_data_valid;
    logic [7:0] fill_data;
    logic       fill_valid;
    logic       wb_valid;
    logic [6:0] wb_addr;
    logic [7:0] wb_data;
`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
    logic [15:0] stat_snp_inv;
`endif

    int tests = 0;
    int fails = 0;

    // Reference line table: state 0=I 1=S 2=M
    logic [1:0] m_state [4];
    logic [4:0] m_tag   [4];
    logic [7:0] m_data  [4];

    snoop_cache_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_op(cpu_op), .cpu_index(cpu_index),
        .cpu_tag(cpu_tag), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_src(bus_src),
        .snp_cmd(snp_cmd), .snp_addr(snp_addr), .snp_src(snp_src),
        .snp_hit(snp_hit), .snp_data(snp_data), .snp_data_valid(snp_data_valid),
        .fill_data(fill_data), .fill_valid(fill_valid),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef SNOOP_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_snp_inv(stat_snp_inv)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [4:0] pick_tag();
        int k;
        k = int'($urandom_range(0, 2));
        case (k)
            0:       return 5'd3;
            1:       return 5'd12;
            default: return 5'd14;
        endcase
    endfunction

    // Foreign (or own) snoop, checked one cycle later and then for its one-cycle width.
    task automatic snoop(input logic [1:0] cmd, input logic [1:0] src, input int idx, input logic [4:0] tag);
        bit act, hit, dirty, dv, wb;
        act   = (cmd != 2'd0) && (src != 2'd0);
        hit   = act && (m_state[idx] != 2'd0) && (m_tag[idx] == tag);
        dirty = (m_state[idx] == 2'd2);
        dv    = hit && dirty && (cmd != 2'd3);
        wb    = hit && dirty && (cmd == 2'd1);
        snp_cmd = cmd; snp_src = src; snp_addr = {tag, 2'(idx)};
        @(posedge clock); #1;
        snp_cmd = 2'd0;
        check("snp_hit", 32'(snp_hit), 32'(hit));
        check("snp_data_valid", 32'(snp_data_valid), 32'(dv));
        if (dv) check("snp_data", 32'(snp_data), 32'(m_data[idx]));
        check("snp_wb_valid", 32'(wb_valid), 32'(wb));
        if (wb) begin
            check("snp_wb_addr", 32'(wb_addr), 32'({tag, 2'(idx)}));
            check("snp_wb_data", 32'(wb_data), 32'(m_data[idx]));
        end
        @(posedge clock); #1;
        check("snp_hit_pulse", 32'(snp_hit), 32'd0);
        if (hit && cmd == 2'd1 && dirty) m_state[idx] = 2'd1;
        else if (hit && cmd != 2'd1) m_state[idx] = 2'd0;
    endtask

    // CPU request; mode 1 injects a foreign BusRdX while arbitrating, mode 2 during lookup.
    task automatic do_req(input bit op, input int idx, input logic [4:0] tag, input logic [7:0] wd,
                          input int gd, input int fd, input logic [7:0] fv, input int mode);
        bit hit, evict, exp_hit;
        bit done = 1'b0;
        bit saw_req = 1'b0;
        bit h = 1'b0;
        logic [1:0] exp_cmd;
        logic [1:0] seen_cmd = 2'd0;
        logic [6:0] seen_addr = 7'd0;
        logic [6:0] wbad = 7'd0;
        logic [7:0] wbd = 8'd0;
        logic [7:0] rd = 8'd0;
        int cyc = 1, rq = 0, fw = -1, ncmd = 0, nwb = 0, wb_cyc = 0, cmd_cyc = 0, inj_cyc = -1;
        if (mode == 2 && m_state[idx] != 2'd0 && m_tag[idx] == tag) m_state[idx] = 2'd0;
        hit   = (m_state[idx] != 2'd0) && (m_tag[idx] == tag);
        evict = !hit && (m_state[idx] == 2'd2);
        if (hit && (!op || m_state[idx] == 2'd2)) exp_cmd = 2'd0;
        else if (hit) exp_cmd = (mode == 1) ? 2'd2 : 2'd3;
        else exp_cmd = op ? 2'd2 : 2'd1;
        exp_hit = hit && (exp_cmd != 2'd2);

        cpu_req_valid = 1'b1; cpu_op = op; cpu_index = 2'(idx); cpu_tag = tag; cpu_wdata = wd;
        @(posedge clock); #1;
        cpu_req_valid = 1'b0;
        while (!done && cyc < 80) begin
            if (cyc == inj_cyc + 1) check("inj_snp_hit", 32'(snp_hit), 32'd1);
            if (bus_req) saw_req = 1'b1;
            if (bus_cmd != 2'd0) begin
                ncmd++; seen_cmd = bus_cmd; seen_addr = bus_addr; cmd_cyc = cyc;
                if (bus_cmd != 2'd3) fw = fd;
            end
            if (wb_valid) begin nwb++; wbad = wb_addr; wbd = wb_data; wb_cyc = cyc; end
            if (cpu_ready) begin
                done = 1'b1; rd = cpu_rdata; h = cpu_hit;
            end else begin
                snp_cmd = 2'd0;
                if ((mode == 1 && bus_req && inj_cyc < 0) || (mode == 2 && cyc == 1)) begin
                    snp_cmd = 2'd2; snp_src = 2'd1; snp_addr = {tag, 2'(idx)}; inj_cyc = cyc;
                end
                bus_gnt = bus_req && (rq >= gd);
                if (bus_req) rq++;
                fill_valid = (fw == 0); fill_data = fv;
                if (fw >= 0) fw--;
                @(posedge clock); #1;
                cyc++;
            end
        end
        snp_cmd = 2'd0; bus_gnt = 1'b0; fill_valid = 1'b0;

        check("cpu_ready", 32'(done), 32'd1);
        check("cpu_hit", 32'(h), 32'(exp_hit));
        if (!op) check("cpu_rdata", 32'(rd), 32'(hit ? m_data[idx] : fv));
        check("bus_cmd_count", 32'(ncmd), (exp_cmd != 2'd0) ? 32'd1 : 32'd0);
        if (exp_cmd != 2'd0) begin
            check("bus_cmd", 32'(seen_cmd), 32'(exp_cmd));
            check("bus_addr", 32'(seen_addr), 32'({tag, 2'(idx)}));
        end
        check("evict_wb_count", 32'(nwb), 32'(evict));
        if (evict) begin
            check("evict_wb_addr", 32'(wbad), 32'({m_tag[idx], 2'(idx)}));
            check("evict_wb_data", 32'(wbd), 32'(m_data[idx]));
            check("wb_before_cmd", 32'(wb_cyc < cmd_cyc), 32'd1);
        end
        if (exp_cmd == 2'd0) begin
            check("hit_latency", 32'(cyc), 32'd2);
            check("hit_no_bus_req", 32'(saw_req), 32'd0);
        end
        @(posedge clock); #1;
        check("cpu_ready_pulse", 32'(cpu_ready), 32'd0);

        if (exp_cmd == 2'd1) begin
            m_state[idx] = 2'd1; m_tag[idx] = tag; m_data[idx] = fv;
        end else if (op) begin
            m_state[idx] = 2'd2; m_tag[idx] = tag; m_data[idx] = wd;
        end
    endtask

    initial begin : main
        bit seen;
        reset = 1'b1; cpu_req_valid = 1'b0; cpu_op = 1'b0; cpu_index = 2'd0; cpu_tag = 5'd0;
        cpu_wdata = 8'd0; bus_gnt = 1'b0; snp_cmd = 2'd0; snp_addr = 7'd0; snp_src = 2'd0;
        fill_data = 8'd0; fill_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin m_state[i] = 2'd0; m_tag[i] = 5'd0; m_data[i] = 8'd0; end
        @(posedge clock); @(posedge clock); #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_cmd", 32'(bus_cmd), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_src", 32'(bus_src), 32'd0);
        check("rst_snp", 32'({snp_hit, snp_data_valid, snp_data}), 32'd0);
        check("rst_wb", 32'({wb_valid, wb_addr, wb_data}), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Cold read miss, then a repeat hit, then upgrade and foreign read of the dirty line.
        do_req(1'b0, 1, 5'd12, 8'd0, 2, 1, 8'd55, 0);
        snoop(2'd1, 2'd1, 1, 5'd12);
        do_req(1'b0, 1, 5'd12, 8'd0, 0, 0, 8'd0, 0);
        do_req(1'b1, 1, 5'd12, 8'd77, 1, 0, 8'd0, 0);
        snoop(2'd1, 2'd1, 1, 5'd12);
        // Re-dirty the line, then a conflicting read evicts it before BusRd.
        do_req(1'b1, 1, 5'd12, 8'd77, 0, 0, 8'd0, 0);
        do_req(1'b0, 1, 5'd14, 8'd0, 0, 0, 8'd33, 0);
        snoop(2'd2, 2'd0, 1, 5'd14);
        snoop(2'd2, 2'd1, 1, 5'd12);
        // Upgrade pending in arbitration loses its S copy and becomes BusRdX.
        do_req(1'b1, 1, 5'd14, 8'h99, 3, 0, 8'd0, 1);
        snoop(2'd2, 2'd2, 1, 5'd14);
        // Snoop on the looked-up index forces the lookup to repeat and miss.
        do_req(1'b0, 3, 5'd7, 8'd0, 0, 0, 8'h42, 0);
        do_req(1'b0, 3, 5'd7, 8'd0, 1, 0, 8'h43, 2);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                snoop(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), pick_tag());
            else
                do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), pick_tag(),
                       8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       8'($urandom), 0);
        end

        // Reset while waiting for a fill abandons the transaction.
        cpu_req_valid = 1'b1; cpu_op = 1'b0; cpu_index = 2'd2; cpu_tag = 5'd5;
        @(posedge clock); #1;
        cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (bus_cmd != 2'd0) seen = 1'b1;
            else begin bus_gnt = bus_req; @(posedge clock); #1; end
        end
        bus_gnt = 1'b0;
        check("wait_fill_reached", 32'(seen), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #2;
        check("rst_mid_ready", 32'(cpu_ready), 32'd0);
        check("rst_mid_bus", 32'({bus_req, bus_cmd}), 32'd0);
        check("rst_mid_wb", 32'(wb_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
`ifdef SNOOP_STATS_EN
        check("stat_hits_rst", 32'(stat_hits), 32'd0);
        check("stat_misses_rst", 32'(stat_misses), 32'd0);
        check("stat_snp_inv_rst", 32'(stat_snp_inv), 32'd0);
`endif
        for (int c = 0; c < 5; c++) begin
            fill_valid = 1'b1; fill_data = 8'hA5;
            @(posedge clock); #1;
            check("post_rst_no_ready", 32'({cpu_ready, wb_valid}), 32'd0);
        end
        fill_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin m_state[i] = 2'd0; m_tag[i] = 5'd0; m_data[i] = 8'd0; end
        for (int i = 0; i < 4; i++) snoop(2'd1, 2'd1, i, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snoop_cache_ctrl.md
SNOOP_CACHE_CTRL -- requirements
Module: snoop_cache_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_BLOCKS, default 4, lines in direct-mapped cache (power of 2, index width IW = log2); TAG_W, default 5, tag width; DATA_W, default 8, line data width; PROC_ID, default 0, 2-bit processor index.
REQ-002 Ports SHALL be, as name direction width meaning: clock in 1 clock; reset in 1 reset, asynchronous, active-high.
REQ-003 cpu_req_valid in 1 request strobe; cpu_op in 1 0=read/1=write; cpu_index in IW line; cpu_tag in TAG_W tag; cpu_wdata in DATA_W write data.
REQ-004 cpu_ready out 1 one-cycle completion pulse; cpu_rdata out DATA_W read data; cpu_hit out 1 completed request hit.
REQ-005 bus_req out 1 bus request; bus_gnt in 1 arbiter grant; bus_cmd out 2 (0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr); bus_addr out TAG_W+IW {tag,index}; bus_src out 2 = PROC_ID.
REQ-006 snp_cmd in 2, snp_addr in TAG_W+IW, snp_src in 2: observed bus transaction; snp_hit out 1, snp_data out DATA_W, snp_data_valid out 1: snoop response.
REQ-007 fill_data in DATA_W, fill_valid in 1: line fill from peer or memory; wb_valid out 1, wb_addr out TAG_W+IW, wb_data out DATA_W: write-back to memory.

Function
REQ-008 Each line SHALL hold state (2 bits: 0=I, 1=S, 2=M), tag and data; hit = tag match and state != I.
REQ-009 FSM SHALL have states IDLE, LOOKUP, EVICT, ARB, WAIT_FILL, DONE.
REQ-010 IDLE: cpu_req_valid SHALL latch op/index/tag/wdata and go to LOOKUP; otherwise stay.
REQ-011 LOOKUP read hit: go DONE, cpu_rdata = line data, cpu_hit=1, state unchanged.
REQ-012 LOOKUP write hit on M: write data, go DONE, cpu_hit=1; write hit on S: go ARB with BusUpgr.
REQ-013 LOOKUP miss: victim M with different tag -> EVICT; else ARB with BusRd (read) or BusRdX (write).
REQ-014 EVICT: pulse wb_valid one cycle with victim {tag,index} and data, victim state -> I, then ARB.
REQ-015 ARB: bus_req=1 held until bus_gnt; on grant cycle drive bus_cmd/bus_addr for exactly one cycle, then BusUpgr -> DONE (line -> M, data written), else -> WAIT_FILL.
REQ-016 WAIT_FILL: on fill_valid install tag; BusRd -> S with fill_data; BusRdX -> M with cpu_wdata; go DONE, cpu_hit=0.
REQ-017 DONE: cpu_ready=1 one cycle, return IDLE; read miss reports fill_data on cpu_rdata.
REQ-018 Snoop SHALL evaluate every cycle when snp_cmd != 0 and snp_src != PROC_ID, independent of FSM state; own transactions ignored.
REQ-019 Snoop hit on line: BusRd on M -> S, supply data, pulse wb_valid with line; BusRd on S -> stays S; BusRdX on M -> I, supply data; BusRdX/BusUpgr on S -> I.
REQ-020 Snoop outputs SHALL be registered: snp_hit/snp_data_valid/snp_data asserted the cycle after snp_cmd, one cycle wide; snp_data_valid only when line was M.
REQ-021 Same-cycle snoop and LOOKUP on same index: snoop update wins; LOOKUP SHALL repeat next cycle against updated state.
REQ-022 Snoop invalidating the target line while in ARB before grant: pending BusUpgr SHALL convert to BusRdX.
REQ-023 Snoop write-back and EVICT write-back in same cycle: snoop wins, EVICT delayed one cycle.

Reset
REQ-024 Reset SHALL force FSM IDLE, all line states I, tags/data 0, and all outputs 0 (cpu_ready, cpu_hit, cpu_rdata, bus_req, bus_cmd, bus_addr, snp_*, wb_*); bus_src = PROC_ID.
REQ-025 Reset mid-transaction SHALL abandon it without cpu_ready or wb_valid pulse.

Configuration
REQ-026 With SNOOP_STATS_EN defined, outputs stat_hits, stat_misses, stat_snp_inv (16 bits each) SHALL count CPU hits, CPU misses at DONE and snoop invalidations, saturating at 16'hFFFF, cleared by reset; without it, these ports and counters SHALL not exist.

Verification
REQ-027 Read index 1 tag 12 on empty cache, grant after 2 cycles, fill 55 -> one BusRd, line S, cpu_rdata=55, cpu_hit=0.
REQ-028 Repeat same read -> cpu_ready 2 cycles after request, cpu_hit=1, no bus_req.
REQ-029 Write 77 to that S line -> BusUpgr, line M data 77; then snoop BusRd same addr from PROC_ID+1 -> next cycle snp_data_valid=1, snp_data=77, wb_valid=1, line S.
REQ-030 Line M tag 12 data 77, read tag 14 same index -> wb_valid with addr {12,idx} data 77 before BusRd issued.
REQ-031 Line S, write hit in ARB, snoop BusRdX same addr before grant -> bus_cmd issued = BusRdX, final line M.
REQ-032 Assert reset in WAIT_FILL -> all states I, no cpu_ready; with SNOOP_STATS_EN, counters read 0.
